// File: rtl/dmem_wait_responder_if.sv
// Request/response bundle between the memory stage (master) and the data-memory responder (slave).
interface dmem_wait_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_wait_responder.sv
// Multi-cycle data-memory responder: one request at a time, WAIT_CYCLES wait states, registered response.
// Define DMEM_MISALIGN_ERR_EN to turn misaligned requests into error responses.
module dmem_wait_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst,
  dmem_wait_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          lat_we;
  logic [AW+1:0] lat_addr;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic          busy_q;
  logic          rsp_err_q;
  logic [31:0]   rsp_rdata_q;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] word_idx;
  logic          misalign;
  logic          do_access;
  logic          wr_en;
  logic          unused_addr;

  assign word_idx  = lat_addr[AW+1:2];
  assign do_access = (state == WAIT) && (cnt == 4'd0);
  assign wr_en     = do_access && lat_we && !misalign;

`ifdef DMEM_MISALIGN_ERR_EN
  assign misalign = (lat_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Upper address bits alias; low bits only matter for the misalign check.
  assign unused_addr = ^{bus.req_addr[31:AW+2], lat_addr[1:0]};

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= 32'd0;
      lat_be      <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            lat_we      <= bus.req_we;
            lat_addr    <= bus.req_addr[AW+1:0];
            lat_wdata   <= bus.req_wdata;
            lat_be      <= bus.req_be;
            cnt         <= 4'(WAIT_CYCLES);
            state       <= WAIT;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= misalign;
            rsp_rdata_q <= (lat_we || misalign) ? 32'd0 : mem[word_idx];
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately unreset so it survives a mid-operation reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) mem[word_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_wait_responder.sv
// Scoreboard bench for dmem_wait_responder: a word-array model predicts each response at accept time,
// and an independent monitor checks data, error flag, latency and hold stability.
module tb_dmem_wait_responder;
  localparam int DEPTH       = 1024;
  localparam int WAIT_CYCLES = 2;
  localparam int LATENCY     = WAIT_CYCLES + 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          accept_cyc;
  } exp_t;

  logic clk;
  logic rst;

  dmem_wait_responder_if sif ();

  dmem_wait_responder #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  exp_t        exp_q[$];
  logic [31:0] ref_mem [int];
  int          cyc       = 0;
  int          tests     = 0;
  int          fails     = 0;
  int          sink_mode = 0;
  bit          in_rsp    = 0;
  logic [31:0] held_rdata;
  logic        held_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic report_fail(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: event did not occur as required (cycle %0d)", name, cyc);
  endtask

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr / 32'd4) % DEPTH);
  endfunction

  // Predicts the response and applies the store to the model; called in the cycle the request is accepted.
  task automatic push_expected(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be);
    exp_t        e;
    int          w;
    logic [31:0] word;
    bit          misal;
    w     = word_of(addr);
    misal = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
    misal = (addr % 4) != 0;
`endif
    word         = ref_mem.exists(w) ? ref_mem[w] : 'x;
    e.accept_cyc = cyc;
    e.err        = misal;
    e.rdata      = (we || misal) ? 32'd0 : word;
    if (we && !misal) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
      end
      ref_mem[w] = word;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be);
    sif.req_valid = 1'b1;
    sif.req_we    = we;
    sif.req_addr  = addr;
    sif.req_wdata = wdata;
    sif.req_be    = be;
  endtask

  task automatic apply_stimulus(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input bit track);
    int guard;
    guard = 0;
    @(posedge clk);
    #1;
    drive_req(we, addr, wdata, be);
    @(negedge clk);
    while (sif.req_ready !== 1'b1) begin
      guard++;
      if (guard > 100) begin
        report_fail("accept_timeout");
        sif.req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (track) push_expected(we, addr, wdata, be);
    @(posedge clk);
    #1;
    sif.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 || in_rsp || sif.busy !== 1'b0) begin
      @(negedge clk);
      guard++;
      if (guard > 500) begin
        report_fail("drain_timeout");
        exp_q.delete();
        return;
      end
    end
  endtask

  // Response sink: rsp_ready is changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (sink_mode)
        1:       sif.rsp_ready = 1'($urandom_range(0, 1));
        2:       sif.rsp_ready = 1'b0;
        default: sif.rsp_ready = 1'b1;
      endcase
    end
  end

  // Monitor: a new response is one seen valid after the previous one was handshaken.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (rst !== 1'b1) begin
        in_rsp = 1'b0;
      end else if (sif.rsp_valid === 1'b1) begin
        if (!in_rsp) begin
          if (exp_q.size() == 0) begin
            report_fail("unexpected_rsp");
          end else begin
            e = exp_q.pop_front();
            check_output("rsp_rdata", sif.rsp_rdata, e.rdata);
            check_output("rsp_err", sif.rsp_err, e.err);
            check_output("latency", cyc - e.accept_cyc, LATENCY);
          end
          in_rsp     = 1'b1;
          held_rdata = sif.rsp_rdata;
          held_err   = sif.rsp_err;
        end else begin
          check_output("hold_rdata", sif.rsp_rdata, held_rdata);
          check_output("hold_err", sif.rsp_err, held_err);
        end
        if (sif.rsp_ready === 1'b1) in_rsp = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    rst           = 1'b0;
    sif.req_valid = 1'b0;
    sif.req_we    = 1'b0;
    sif.req_addr  = 32'd0;
    sif.req_wdata = 32'd0;
    sif.req_be    = 4'd0;
    sif.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_output("rst_req_ready", sif.req_ready, 0);
    check_output("rst_rsp_valid", sif.rsp_valid, 0);
    check_output("rst_rsp_rdata", sif.rsp_rdata, 0);
    check_output("rst_rsp_err", sif.rsp_err, 0);
    check_output("rst_busy", sif.busy, 0);
    rst = 1'b1;
    @(negedge clk);
    check_output("idle_req_ready", sif.req_ready, 1);
    check_output("idle_busy", sif.busy, 0);

    // Basic store then load.
    apply_stimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    wait_drain();
    apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    wait_drain();

    // Partial byte-enable merge.
    apply_stimulus(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b1);
    wait_drain();
    apply_stimulus(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1);
    wait_drain();
    apply_stimulus(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
    wait_drain();

    // Backpressure with a second request held pending.
    sink_mode = 2;
    apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    drive_req(1'b0, 32'h20, 32'h0, 4'h0);
    guard = 0;
    while (sif.rsp_valid !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) report_fail("bp_rsp_timeout");
    repeat (5) begin
      @(negedge clk);
      check_output("bp_req_ready", sif.req_ready, 0);
      check_output("bp_rsp_valid", sif.rsp_valid, 1);
    end
    sink_mode = 0;
    guard = 0;
    while (!(sif.rsp_valid === 1'b1 && sif.rsp_ready === 1'b1) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) report_fail("bp_release_timeout");
    @(negedge clk);
    check_output("bp_req_ready_after", sif.req_ready, 1);
    check_output("bp_rsp_valid_after", sif.rsp_valid, 0);
    push_expected(1'b0, 32'h20, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    sif.req_valid = 1'b0;
    wait_drain();

    // Reset while a store is waiting: the store must be dropped.
    apply_stimulus(1'b1, 32'h30, 32'h0, 4'hF, 1'b1);
    wait_drain();
    apply_stimulus(1'b1, 32'h30, 32'h12345678, 4'hF, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_output("midrst_rsp_valid", sif.rsp_valid, 0);
    check_output("midrst_req_ready", sif.req_ready, 0);
    check_output("midrst_busy", sif.busy, 0);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1'b0, 32'h30, 32'h0, 4'h0, 1'b1);
    wait_drain();

`ifdef DMEM_MISALIGN_ERR_EN
    apply_stimulus(1'b1, 32'h40, 32'h5A5A1234, 4'hF, 1'b1);
    wait_drain();
    apply_stimulus(1'b1, 32'h42, 32'hFFFFFFFF, 4'hF, 1'b1);
    wait_drain();
    apply_stimulus(1'b0, 32'h40, 32'h0, 4'h0, 1'b1);
    wait_drain();
`endif

    // Randomised traffic over 32 preloaded words with aliased upper address bits.
    for (int k = 0; k < 32; k++) begin
      apply_stimulus(1'b1, 32'(k * 4), $urandom(), 4'hF, 1'b1);
      wait_drain();
    end
    sink_mode = 1;
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      bit          we;
      logic [1:0]  low;
      we  = 1'($urandom_range(0, 1));
      d   = $urandom();
      be  = 4'($urandom_range(0, 15));
      low = 2'($urandom_range(0, 3));
`ifdef DMEM_MISALIGN_ERR_EN
      if ($urandom_range(0, 7) != 0) low = 2'b00;
`endif
      a = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'(low);
      apply_stimulus(we, a, d, be, 1'b1);
      wait_drain();
    end
    sink_mode = 0;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_wait_responder.md
# dmem_wait_responder

Multi-cycle data-memory responder that serves the load/store requests issued by the pipeline's memory stage. It accepts one request at a time over a valid/ready handshake. It holds the request for a programmable number of wait states, performs the word access with per-byte write enables, and returns a registered response over a second valid/ready handshake. The memory stage stalls on `busy` and consumes `rsp_rdata` for the writeback pipeline register.

## Interface
- `DEPTH`, 1024: number of 32-bit words; power of two, 16..65536.
- `WAIT_CYCLES`, 2: wait states between accept and access, 0..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: responder can accept a request.
- `req_we` input 1: 1 = store, 0 = load.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, little-endian lanes.
- `req_be` input 4: store byte enables; bit i selects byte lane i. Ignored for loads.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer takes the response.
- `rsp_rdata` output 32: load data; 0 for stores.
- `rsp_err` output 1: access error flag, only meaningful with the macro in Configuration.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- There are three states: IDLE, WAIT and RESP. The state register and `cnt` (4 bits) reset to IDLE and 0.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid` && `req_ready`, latch `req_we`, `req_addr`, `req_wdata` and `req_be`.
  - Load `cnt` = `WAIT_CYCLES` and go to WAIT.
- WAIT:
  - `req_ready` = 0.
  - If `cnt` != 0, decrement `cnt`.
  - If `cnt` == 0, perform the access and go to RESP.
- Access:
  - Word index = latched `addr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses alias modulo `DEPTH`*4.
  - Store: write only the lanes with `be` bit = 1; other lanes keep their value. `rsp_rdata` is loaded with 0.
  - Load: `rsp_rdata` is loaded with the full stored word. A store with `be` = 0000 leaves memory unchanged and still responds.
- RESP:
  - `rsp_valid` = 1, and `rsp_rdata` and `rsp_err` are held stable.
  - On `rsp_ready`, go to IDLE; `rsp_valid` falls on the same edge.
  - `rsp_rdata` keeps its last value until the next access.
- Only one request is outstanding at a time; there is no request queue.
- `rsp_valid` is registered, and `req_ready`/`busy` decode only from the state. No input feeds any output combinationally.
- Memory contents are not reset; a load from an unwritten word returns X in simulation.

## Timing
- Reset values while `rst` is low:
  - `req_ready` = 0.
  - `rsp_valid` = 0.
  - `rsp_rdata` = 0.
  - `rsp_err` = 0.
  - `busy` = 0.
- After reset deasserts, `req_ready` = 1 from the first cycle.
- Latency: a request accepted in cycle 0 produces `rsp_valid` = 1 in cycle `WAIT_CYCLES`+2.
  - Example: with `WAIT_CYCLES`=0, response in cycle 2; with `WAIT_CYCLES`=2, response in cycle 4.
- A store becomes visible to a load accepted after that store's response handshake.
- `rsp_ready` held high makes the response last one cycle. `req_ready` returns to 1 in the following cycle, so the minimum request spacing is `WAIT_CYCLES`+3 cycles.
- Backpressure: `rsp_ready` low holds RESP indefinitely with outputs stable. `req_valid` arriving during WAIT or RESP is not accepted, and the requester must hold it.
- `rsp_ready` high outside RESP is ignored.
- Reset mid-operation: a store still in WAIT is dropped and never written. A response held in RESP is discarded. Memory already written is retained.

## Configuration
- Macro: `DMEM_MISALIGN_ERR_EN`.
- Defined:
  - A request with latched `addr[1:0]` != 00 raises the error response: `rsp_err` = 1 in RESP, no memory write, `rsp_rdata` = 0.
  - Aligned requests respond with `rsp_err` = 0.
  - Latency is unchanged.
- Undefined:
  - `addr[1:0]` is ignored and the access uses the containing word.
  - `rsp_err` is tied to 0.

## Test plan
- Reset/idle: hold `rst` low 3 cycles and release.
  - Required: all outputs 0 during reset; then `req_ready`=1 and `busy`=0.
- Store/load at `WAIT_CYCLES`=2:
  - Store 0xDEADBEEF to 0x10 with `be`=1111, then load 0x10.
  - Required: `rsp_valid` in cycle 4 after each accept; load returns 0xDEADBEEF.
- Byte enables:
  - Store 0x11223344 to 0x20 (`be`=1111), then store 0xAABBCCDD (`be`=0101), then load 0x20.
  - Required: load returns 0x11BB33DD.
- Backpressure:
  - Hold `rsp_ready`=0 for 5 cycles in RESP while `req_valid`=1.
  - Required: `rsp_valid`/`rsp_rdata` stable, `req_ready`=0, no second accept. Release gives one response, then `req_ready`=1 the next cycle.
- Reset mid-operation:
  - Store 0x12345678 to 0x30 over an old value of 0x0; assert `rst` in WAIT.
  - Required: a later load of 0x30 returns 0x0.
- Misalign with the macro defined:
  - Store 0xFFFFFFFF to 0x42 (`be`=1111).
  - Required: `rsp_err`=1 and `rsp_rdata`=0. A later load of 0x40 returns the prior value; an aligned load gives `rsp_err`=0.
